// File: rtl/read_framer.sv
// Read framer: packs a serial 2-bit symbol stream into words, routes N-1 reads
// to the restore stage and merges restored and intact reads back in order.
module read_framer #(
  parameter int N           = 18,
  parameter int RESTORE_LAT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [1:0]       sym,
  input  logic             sym_last,
  input  logic             sym_rev,
  output logic [2*N-3:0]   restore_word,
  output logic             restore_rev,
  input  logic [2*N-1:0]   restore_word_in,
  output logic [2*N-1:0]   word_out,
  output logic             word_valid,
  output logic [1:0]       word_status,
  output logic             len_err
);

  localparam int LW = $clog2(N + 2);
  localparam int PD = RESTORE_LAT + 1;
  localparam logic [LW-1:0] LEN_SHORT = LW'(N - 1);
  localparam logic [LW-1:0] LEN_FULL  = LW'(N);
  localparam logic [LW-1:0] LEN_SAT   = LW'(N + 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;
  typedef enum logic [1:0] {ST_CLEAN = 2'b00, ST_RESTORED = 2'b01} status_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  len_q, len_d, len_inc;
  logic [2*N-1:0] buf_q, buf_d, buf_ins;
  logic           rev_q, rev_d, flag_cur;
  logic           done, is_short, is_full;

  logic [2*N-3:0] restore_word_q;
  logic           restore_rev_q;
  logic           len_err_q;
  logic [2*N-1:0] word_out_q;
  logic           word_valid_q;
  status_t        word_status_q;

  logic           pipe_vld_q  [PD];
  status_t        pipe_sts_q  [PD];
  logic [2*N-1:0] pipe_word_q [PD];

  // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    buf_d    = buf_q;
    rev_d    = rev_q;
    done     = 1'b0;
    len_inc  = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
    buf_ins  = (len_q < LEN_FULL) ? (buf_q | ({sym, {(2*N-2){1'b0}}} >> {len_q, 1'b0})) : buf_q;
    flag_cur = (state_q == S_IDLE) ? sym_rev : rev_q;
    if (sym_valid) begin
      len_d = len_inc;
      buf_d = buf_ins;
      rev_d = flag_cur;
      if (sym_last) begin
        done    = 1'b1;
        state_d = S_IDLE;
        len_d   = '0;
        buf_d   = '0;
      end else begin
        state_d = S_COLLECT;
      end
    end
    is_short = done && (len_inc == LEN_SHORT);
    is_full  = done && (len_inc == LEN_FULL);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      buf_q          <= '0;
      rev_q          <= 1'b0;
      restore_word_q <= '0;
      restore_rev_q  <= 1'b0;
      len_err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      buf_q     <= buf_d;
      rev_q     <= rev_d;
      len_err_q <= done && !is_short && !is_full;
      if (is_short) begin
        restore_word_q <= buf_ins[2*N-1:2];
        restore_rev_q  <= flag_cur;
      end
    end
  end

  // Control bits of the alignment pipe are reset so no stale entry survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PD; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_sts_q[i] <= ST_CLEAN;
      end
    end else begin
      pipe_vld_q[0] <= is_short || is_full;
      pipe_sts_q[0] <= is_short ? ST_RESTORED : ST_CLEAN;
      for (int i = 1; i < PD; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_sts_q[i] <= pipe_sts_q[i-1];
      end
    end
  end

  // NOTE: pipe data words are qualified by their valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    pipe_word_q[0] <= is_full ? buf_ins : '0;
    for (int i = 1; i < PD; i++) pipe_word_q[i] <= pipe_word_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_out_q    <= '0;
      word_valid_q  <= 1'b0;
      word_status_q <= ST_CLEAN;
    end else begin
      word_valid_q <= pipe_vld_q[PD-1];
      if (pipe_vld_q[PD-1]) begin
        word_status_q <= pipe_sts_q[PD-1];
        word_out_q    <= (pipe_sts_q[PD-1] == ST_RESTORED) ? restore_word_in : pipe_word_q[PD-1];
      end
    end
  end

  assign restore_word = restore_word_q;
  assign restore_rev  = restore_rev_q;
  assign len_err      = len_err_q;
  assign word_out     = word_out_q;
  assign word_valid   = word_valid_q;
  assign word_status  = word_status_q;

endmodule

// File: doc/read_framer.md
# read_framer

Upstream framing stage for single-deletion restoration. It accepts the serial nucleotide stream of one read at a time (2-bit symbols, one per cycle, read delimited by a last flag) and packs it into a word. It classifies each read by length and sends length-N-1 reads to the restore stage. It then merges the restored word with intact length-N reads, delayed to match, into one in-order output word stream.

## Interface
Parameters:
- N, 18, code word length in symbols.
- RESTORE_LAT, 5, clock edges from restore_word/restore_rev stable to restore_word_in valid; must equal the restore stage pipeline depth.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset: asynchronous, active-high.
- sym_valid  in  1  symbol present this cycle.
- sym  in  2  nucleotide symbol.
- sym_last  in  1  qualifies sym_valid; final symbol of the read.
- sym_rev  in  1  strand flag; sampled with the first symbol of a read.
- restore_word  out  2*(N-1)  packed short read to the restore stage.
- restore_rev  out  1  strand flag of that read; drives reverse_needed.
- restore_word_in  in  2*N  restored word from the restore stage.
- word_out  out  2*N  final word.
- word_valid  out  1  one-cycle pulse: word_out/word_status valid.
- word_status  out  2  00 clean (length N), 01 restored (length N-1).
- len_err  out  1  one-cycle pulse: read length not in {N-1, N}; no word produced.

## Operation
- No backpressure. One symbol is accepted on every cycle with sym_valid=1.
- Read state: IDLE (no symbols since last read end) and COLLECT.
  - IDLE: a sym_valid cycle latches sym_rev into the read flag and moves to COLLECT, unless sym_last is also 1, which completes a 1-symbol read.
  - COLLECT: sym_valid with sym_last=1 completes the read and returns to IDLE.
- Length counter L has width $clog2(N+2). It counts accepted symbols of the current read and saturates at N+1. Symbols beyond N are not stored.
- Packing: the first symbol goes to the most significant pair. Symbol k (0-based) goes to bits [2N-1-2k : 2N-2-2k] of a 2N-bit shift buffer. The shift buffer clears when a read completes.
- On read completion with final length L:
  - L==N-1: restore_word <= buffer[2N-1:2]; restore_rev <= read flag. A status entry "restored" enters the alignment pipe.
  - L==N: the full buffer enters the bypass pipe with status "clean".
  - Otherwise: len_err pulses the next cycle. Nothing enters the pipes.
- restore_word/restore_rev hold their value until the next length-(N-1) read completes.
- Alignment pipe: RESTORE_LAT+1 stages, each holding {valid, status, 2N-bit bypass word}. At the pipe exit:
  - word_out = restore_word_in if status is restored.
  - word_out = the bypass word if status is clean.
- Output order equals read completion order.
- Minimum read spacing is N-1 cycles, which is at least the restore latency, so at most one read is in the restore stage per completion. A pipe slot carries one entry per cycle; no collision is possible.

## Timing
- A read whose last symbol is sampled at edge t:
  - len_err (if any) is high during cycle t..t+1, one cycle.
  - For a short read, restore_word is stable from edge t onward.
  - word_valid is high for one cycle after edge t+RESTORE_LAT+1. word_out/word_status are registered and valid in that same cycle.
- Back-to-back reads: a new read's first symbol may arrive in the cycle after sym_last.
- Reset, all cleared: word_out=0, word_valid=0, word_status=00, len_err=0, restore_word=0, restore_rev=0, counter=0, state IDLE, pipe valid bits 0.
- A partial read interrupted by reset is discarded. In-flight pipe entries are discarded; no word_valid follows reset.
- sym_valid=0 cycles inside a read are allowed (gaps) and do not affect the count.

## Test plan
- 18 symbols A,C,G,T repeated (00,01,10,11...), last on 18th -> word_valid once, RESTORE_LAT+1 cycles after the last edge, word_status=00, word_out=36'h1B1B1B1B1 packed MSB-first.
- 17 symbols, sym_rev=1 on first -> restore_word equals the packed 34 bits, restore_rev=1. With a stub returning a known 36-bit value after RESTORE_LAT -> word_out equals that value, word_status=01.
- Read of 16 symbols, then a read of 20 symbols -> two len_err pulses, no word_valid. Following 18-symbol read still produces a correct clean word.
- Alternating 17- and 18-symbol reads back-to-back with no gaps -> outputs in order, statuses 01,00,01,00, each RESTORE_LAT+1 after its last edge.
- 18-symbol read with random sym_valid gaps -> same word as the gapless case.
- rst asserted mid-read and again with a word in the pipe -> all outputs 0 immediately, no stale word_valid. Next full read decodes correctly.
